// File: rtl/dff_debounce_edge.sv
// Debounces the registered bit D into a clean level with one-cycle Rise/Fall pulses.
// Latency: a new level held from edge k appears on Q_level after edge k+STABLE_CYCLES-1; no backpressure.
// Optional DFF_DEBOUNCE_EDGE_COUNT_EN adds a saturating Rise counter with synchronous clear.
module dff_debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        D,
  output logic        Q_level,
  output logic        Rise,
  output logic        Fall,
  output logic        Busy
`ifdef DFF_DEBOUNCE_EDGE_COUNT_EN
  ,
  input  logic        Count_clr,
  output logic [15:0] Edge_count
`endif
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_t;

  localparam state_t                RST_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam bit                    SINGLE    = (STABLE_CYCLES == 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_d, rise_d, fall_d, busy_d;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      Q_level <= RESET_LEVEL;
      Rise    <= 1'b0;
      Fall    <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      Q_level <= level_d;
      Rise    <= rise_d;
      Fall    <= fall_d;
      Busy    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = Q_level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (D) begin
          // With a single required sample the new level is accepted on first sight.
          if (SINGLE) begin
            state_d = STABLE_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = CHECK_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHECK_HI: begin
        if (!D) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!D) begin
          if (SINGLE) begin
            state_d = STABLE_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = CHECK_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHECK_LO: begin
        if (D) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == CHECK_HI) || (state_d == CHECK_LO);
  end

`ifdef DFF_DEBOUNCE_EDGE_COUNT_EN
  // Clear wins over an increment landing in the same cycle.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Edge_count <= '0;
    end else if (Count_clr) begin
      Edge_count <= '0;
    end else if (Rise && (Edge_count != 16'hFFFF)) begin
      Edge_count <= Edge_count + 16'd1;
    end
  end
`endif

endmodule
